// File: rtl/led_matrix_pkg.sv
// Shared types for the 8x8 LED matrix scanner.
// Row/column geometry and scan FSM state encoding.
package led_matrix_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  typedef logic [2:0] row_t;

endpackage

// File: rtl/scan_timer.sv
// Reloadable down-counter; done on terminal count 1.
// done_next predicts done for the following cycle.
module scan_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done,
  output logic         done_next
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == W'(1));

  // widened compare so a 1-bit timer cannot alias 2 onto 0
  always_comb begin
    done_next = 1'b0;
    if (load) begin
      done_next = (load_value == W'(1));
    end else begin
      done_next = ({1'b0, count} == (W+1)'(2));
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Double-buffered 8x8 LED row scanner with blanking gaps.
// Outputs are registered from next-state values.
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int DWELL_CYCLES = 4096,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ROWS*COLS-1:0] grid,
  input  logic                 grid_valid,
  output logic [ROWS-1:0]      row_sel,
  output logic [COLS-1:0]      col_data,
  output logic                 frame_done
);

  localparam int MAXC =
    (DWELL_CYCLES > BLANK_CYCLES) ?
    DWELL_CYCLES : BLANK_CYCLES;
  localparam int TW = $clog2(MAXC + 1);
  localparam logic [TW-1:0] DWELL_V = TW'(DWELL_CYCLES);
  localparam logic [TW-1:0] BLANK_V = TW'(BLANK_CYCLES);
  localparam row_t LAST_ROW = row_t'(ROWS - 1);

  scan_state_t state, state_d;
  row_t        row, row_d;

  logic [ROWS*COLS-1:0] disp_buf, disp_d;
  logic [ROWS*COLS-1:0] stage_buf, stage_d;
  logic                 pending, pending_d;

  logic [ROWS-1:0] row_sel_d;
  logic [COLS-1:0] col_data_d;
  logic            frame_done_d;

  logic          ld;
  logic [TW-1:0] ld_val;
  logic          tdone;
  logic          tdone_next;
  logic          swap;

  scan_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (ld),
    .load_value (ld_val),
    .done       (tdone),
    .done_next  (tdone_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      row        <= '0;
      disp_buf   <= '0;
      stage_buf  <= '0;
      pending    <= 1'b0;
      row_sel    <= '0;
      col_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      row        <= row_d;
      disp_buf   <= disp_d;
      stage_buf  <= stage_d;
      pending    <= pending_d;
      row_sel    <= row_sel_d;
      col_data   <= col_data_d;
      frame_done <= frame_done_d;
    end
  end

  always_comb begin
    state_d   = state;
    row_d     = row;
    disp_d    = disp_buf;
    stage_d   = stage_buf;
    pending_d = pending;
    ld        = 1'b0;
    ld_val    = BLANK_V;
    swap      = 1'b0;

    if (grid_valid) begin
      stage_d = grid;
    end

    unique case (state)
      IDLE: begin
        if (grid_valid) begin
          state_d   = BLANK;
          row_d     = '0;
          disp_d    = grid;
          pending_d = 1'b0;
          ld        = 1'b1;
          ld_val    = BLANK_V;
        end
      end
      BLANK: begin
        if (tdone) begin
          state_d = DRIVE;
          ld      = 1'b1;
          ld_val  = DWELL_V;
        end
      end
      DRIVE: begin
        if (tdone) begin
          state_d = BLANK;
          ld      = 1'b1;
          ld_val  = BLANK_V;
          if (row == LAST_ROW) begin
            row_d = '0;
            swap  = 1'b1;
          end else begin
            row_d = row + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state != IDLE && grid_valid && !swap) begin
      pending_d = 1'b1;
    end

    // a strobe on the swap cycle bypasses the stage buffer
    if (swap) begin
      if (grid_valid) begin
        disp_d    = grid;
        pending_d = 1'b0;
      end else if (pending) begin
        disp_d    = stage_buf;
        pending_d = 1'b0;
      end
    end
  end

  always_comb begin
    row_sel_d    = '0;
    col_data_d   = '0;
    frame_done_d = 1'b0;
    if (state_d == DRIVE) begin
      row_sel_d    = 8'd1 << row_d;
      col_data_d   = disp_d[{row_d, 3'b000} +: COLS];
      frame_done_d = (row_d == LAST_ROW) && tdone_next;
    end
  end

endmodule
